// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with parallel load, wrap-or-saturate boundary mode,
// a combinational look-ahead value and registered/sticky boundary-event flags.
module updown_mod_counter #(
   parameter int WIDTH    = 4,
   parameter int MAX      = (1 << WIDTH) - 1,
   parameter int SATURATE = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   input  logic             INC,
   input  logic             DEC,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] NXT,
   output logic             TC,
   output logic             EVT,
   output logic             OVF
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic             SAT_V = (SATURATE != 0);

   logic [WIDTH-1:0] q_q, q_d;
   logic             evt_q, evt_d;
   logic             ovf_q, ovf_d;

   logic up, dn, at_max, at_zero, clear, override;

   always_comb begin
      up       = INC & ~DEC;
      dn       = DEC & ~INC;
      at_max   = (q_q == MAX_V);
      at_zero  = (q_q == '0);
      clear    = RST | CLR;
      override = clear | LD;

      // Boundary is decided before any arithmetic, so no carry/borrow
      // ever escapes the 0..MAX range.
      evt_d = ~override & ((up & at_max) | (dn & at_zero));

      q_d = q_q;
      if (clear) begin
         q_d = '0;
      end else if (LD) begin
         q_d = (D > MAX_V) ? MAX_V : D;
      end else if (up) begin
         if (at_max) q_d = SAT_V ? MAX_V : '0;
         else        q_d = q_q + 1'b1;
      end else if (dn) begin
         if (at_zero) q_d = SAT_V ? '0 : MAX_V;
         else         q_d = q_q - 1'b1;
      end

      ovf_d = clear ? 1'b0 : (ovf_q | evt_d);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_q   <= '0;
         evt_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         evt_q <= evt_d;
         ovf_q <= ovf_d;
      end
   end

   // TC is the same-cycle boundary condition so a following stage can chain on it.
   assign Q   = q_q;
   assign NXT = q_d;
   assign TC  = evt_d;
   assign EVT = evt_q;
   assign OVF = ovf_q;

endmodule
